div_seq: RTL and testbench

Sequential 32-bit integer divider for the multicycle MIPS datapath, implementing `div` and `divu`. It sits beside the ALU. It takes operands from the A and B registers and feeds the quotient and remainder through the HI/LO select muxes into the Hi and Lo registers. The control unit starts it with a one-cycle pulse and waits for `done` before loading HiLo. Division uses a restoring shift-subtract iteration, one quotient bit per clock.

---
 rtl/div_seq.sv | 157 +++++++++++++++
 tb/tb_div_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider for div/divu, one quotient bit per clock.
// Optional macro DIV_SIGNED_EN adds signed (div) support; without it the block is divu only.
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state;
    state_t state_next;

    logic [4:0]  count;
    logic [32:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dvsr_r;

    logic        accept;
    logic        zero_req;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] lo_fix;
    logic [31:0] hi_fix;

    logic [33:0] shifted;
    logic [33:0] trial;

    // One restoring step: shift in the next dividend bit and try to subtract the divisor.
    assign shifted = {rem_r, quo_r[31]};
    assign trial   = shifted - {2'b00, dvsr_r};

`ifdef DIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic q_neg;
    logic r_neg;

    assign a_neg  = is_signed & dividend[31];
    assign b_neg  = is_signed & divisor[31];
    assign a_mag  = a_neg ? (32'd0 - dividend) : dividend;
    assign b_mag  = b_neg ? (32'd0 - divisor) : divisor;
    assign lo_fix = q_neg ? (32'd0 - quo_r) : quo_r;
    assign hi_fix = r_neg ? (32'd0 - rem_r[31:0]) : rem_r[31:0];
`else
    logic sign_unused;

    assign sign_unused = is_signed;
    assign a_mag       = dividend;
    assign b_mag       = divisor;
    assign lo_fix      = quo_r;
    assign hi_fix      = rem_r[31:0];
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        zero_req   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor == 32'd0) begin
                        zero_req = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (count == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Results only change in FIX, so hi/lo survive a divide-by-zero or a new start.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 5'd0;
            rem_r    <= 33'd0;
            quo_r    <= 32'd0;
            dvsr_r   <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
            div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (zero_req) begin
                done     <= 1'b1;
                div_zero <= 1'b1;
            end
            if (accept) begin
                div_zero <= 1'b0;
                count    <= 5'd0;
                rem_r    <= 33'd0;
                quo_r    <= a_mag;
                dvsr_r   <= b_mag;
`ifdef DIV_SIGNED_EN
                q_neg    <= a_neg ^ b_neg;
                r_neg    <= a_neg;
`endif
            end
            if (state == CALC) begin
                count <= count + 5'd1;
                if (!trial[33]) begin
                    rem_r <= trial[32:0];
                    quo_r <= {quo_r[30:0], 1'b1};
                end else begin
                    rem_r <= shifted[32:0];
                    quo_r <= {quo_r[30:0], 1'b0};
                end
            end
            if (state == FIX) begin
                hi   <= hi_fix;
                lo   <= lo_fix;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed scenarios plus randomized operations
// compared against an arithmetic reference model (follows DIV_SIGNED_EN if defined).
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    div_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // MIPS semantics straight from integer arithmetic: truncating quotient, remainder takes dividend sign.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        longint tq;
        longint tr;
        if (s && SIGNED_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'h0, a};
            sb = {32'h0, b};
        end
        tq = sa / sb;
        tr = sa % sb;
        q  = tq[31:0];
        r  = tr[31:0];
    endfunction

    // Must be entered at a negedge; returns at the negedge where done is seen (or the bound expires).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output logic [31:0] h, output logic [31:0] l,
                          output logic dz, output logic busy_first);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(negedge clk);
        start      = 1'b0;
        dividend   = $urandom;
        divisor    = $urandom;
        is_signed  = 1'($urandom_range(0, 1));
        lat        = 1;
        busy_first = busy;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        h  = hi;
        l  = lo;
        dz = div_zero;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (2) @(negedge clk);
        total++; if (hi !== 32'd0) begin bad++; $display("[TB] FAIL reset_hi got=%h want=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("[TB] FAIL reset_lo got=%h want=0", lo); end
        total++; if ({busy, done, div_zero} !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_flags got=%b want=000", {busy, done, div_zero});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned_basic();
        int lat; logic [31:0] h, l; logic dz, bf;
        run_op(32'd100, 32'd7, 1'b0, lat, h, l, dz, bf);
        total++; if (lat !== 34) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=34", lat); end
        total++; if (l !== 32'd14) begin bad++; $display("[TB] FAIL basic_lo got=%h want=%h", l, 32'd14); end
        total++; if (h !== 32'd2) begin bad++; $display("[TB] FAIL basic_hi got=%h want=%h", h, 32'd2); end
        total++; if (bf !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_running got=%b want=1", bf); end
        total++; if (dz !== 1'b0) begin bad++; $display("[TB] FAIL basic_div_zero got=%b want=0", dz); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_at_done got=%b want=0", busy); end
        @(negedge clk);
        total++; if ({done, busy} !== 2'b00) begin
            bad++; $display("[TB] FAIL basic_done_pulse got done,busy=%b want=00", {done, busy});
        end
    endtask

    task automatic test_signed_rules();
        int lat; logic [31:0] h, l; logic dz, bf;
        logic [31:0] av [3] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9};
        logic [31:0] bv [3] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] sq [3] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3};
        logic [31:0] sr [3] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
        logic [31:0] uq [3] = '{32'h7FFFFFFC, 32'd0, 32'd0};
        logic [31:0] ur [3] = '{32'd1, 32'd7, 32'hFFFFFFF9};
        logic [31:0] eq, er;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], 1'b1, lat, h, l, dz, bf);
            eq = SIGNED_EN ? sq[i] : uq[i];
            er = SIGNED_EN ? sr[i] : ur[i];
            total++; if (l !== eq || lat !== 34) begin
                bad++; $display("[TB] FAIL sign_lo[%0d] got=%h lat=%0d want=%h lat=34", i, l, lat, eq);
            end
            total++; if (h !== er) begin bad++; $display("[TB] FAIL sign_hi[%0d] got=%h want=%h", i, h, er); end
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] h, l; logic dz, bf;
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, h, l, dz, bf);
        total++; if (l !== (SIGNED_EN ? 32'h80000000 : 32'd0)) begin
            bad++; $display("[TB] FAIL ovf_lo got=%h want=%h", l, SIGNED_EN ? 32'h80000000 : 32'd0);
        end
        total++; if (h !== (SIGNED_EN ? 32'd0 : 32'h80000000)) begin
            bad++; $display("[TB] FAIL ovf_hi got=%h want=%h", h, SIGNED_EN ? 32'd0 : 32'h80000000);
        end
        total++; if (dz !== 1'b0) begin bad++; $display("[TB] FAIL ovf_div_zero got=%b want=0", dz); end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] h, l; logic dz, bf;
        run_op(32'd9, 32'd4, 1'b0, lat, h, l, dz, bf);
        total++; if ({h, l} !== {32'd1, 32'd2}) begin
            bad++; $display("[TB] FAIL dz_preload got hi=%h lo=%h want hi=1 lo=2", h, l);
        end
        run_op(32'd5, 32'd0, 1'b0, lat, h, l, dz, bf);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL dz_latency got=%0d want=1", lat); end
        total++; if (dz !== 1'b1) begin bad++; $display("[TB] FAIL dz_flag got=%b want=1", dz); end
        total++; if ({h, l} !== {32'd1, 32'd2}) begin
            bad++; $display("[TB] FAIL dz_hold got hi=%h lo=%h want hi=1 lo=2", h, l);
        end
        @(negedge clk);
        total++; if ({done, div_zero} !== 2'b01) begin
            bad++; $display("[TB] FAIL dz_after got done,div_zero=%b want=01", {done, div_zero});
        end
        run_op(32'd9, 32'd3, 1'b0, lat, h, l, dz, bf);
        total++; if (dz !== 1'b0 || l !== 32'd3 || h !== 32'd0) begin
            bad++; $display("[TB] FAIL dz_clear got dz=%b lo=%h hi=%h want dz=0 lo=3 hi=0", dz, l, h);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int cycle = 1; int ndone = 0; int first = 0;
        logic [31:0] h = 32'hX; logic [31:0] l = 32'hX;
        start = 1'b1; dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
        @(negedge clk);
        forever begin
            if (done) begin
                ndone++;
                if (first == 0) begin first = cycle; h = hi; l = lo; end
            end
            if (cycle == 10) begin start = 1'b1; dividend = 32'd9; divisor = 32'd3; end
            else start = 1'b0;
            if (cycle == 45) break;
            @(negedge clk);
            cycle++;
        end
        start = 1'b0;
        total++; if (ndone !== 1 || first !== 34) begin
            bad++; $display("[TB] FAIL busy_ignore got done_count=%0d first=%0d want 1 at 34", ndone, first);
        end
        total++; if ({l, h} !== {32'd10, 32'd0}) begin
            bad++; $display("[TB] FAIL busy_result got lo=%h hi=%h want lo=a hi=0", l, h);
        end
    endtask

    task automatic test_reset_mid();
        int cycle = 1; int ndone = 0;
        int lat; logic [31:0] h, l; logic dz, bf;
        start = 1'b1; dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (cycle < 15) begin @(negedge clk); cycle++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if ({hi, lo} !== 64'd0) begin
            bad++; $display("[TB] FAIL rstmid_result got hi=%h lo=%h want 0", hi, lo);
        end
        total++; if ({busy, done, div_zero} !== 3'b000) begin
            bad++; $display("[TB] FAIL rstmid_flags got=%b want=000", {busy, done, div_zero});
        end
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("[TB] FAIL rstmid_no_done got=%0d want=0", ndone); end
        run_op(32'd9, 32'd3, 1'b0, lat, h, l, dz, bf);
        total++; if ({l, h} !== {32'd3, 32'd0} || lat !== 34) begin
            bad++; $display("[TB] FAIL rstmid_fresh got lo=%h hi=%h lat=%0d want lo=3 hi=0 lat=34", l, h, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] h, l; logic dz, bf;
        run_op(32'd1000, 32'd10, 1'b0, lat, h, l, dz, bf);
        total++; if ({l, h} !== {32'd100, 32'd0} || lat !== 34) begin
            bad++; $display("[TB] FAIL b2b_first got lo=%h hi=%h lat=%0d want lo=64 hi=0 lat=34", l, h, lat);
        end
        run_op(32'd77, 32'd9, 1'b0, lat, h, l, dz, bf);
        total++; if ({l, h} !== {32'd8, 32'd5} || lat !== 34) begin
            bad++; $display("[TB] FAIL b2b_second got lo=%h hi=%h lat=%0d want lo=8 hi=5 lat=34", l, h, lat);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] h, l; logic dz, bf;
        logic [31:0] a, b, eq, er, prev_h, prev_l;
        logic s;
        prev_l = 32'd8;
        prev_h = 32'd5;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = ($urandom_range(0, 1) == 1) ? (32'd0 - 32'($urandom_range(1, 16))) : 32'($urandom_range(1, 16));
                2:       b = 32'd0;
                default: b = $urandom & 32'h000000FF;
            endcase
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, lat, h, l, dz, bf);
            if (b == 32'd0) begin
                total++; if (lat !== 1 || dz !== 1'b1 || {h, l} !== {prev_h, prev_l}) begin
                    bad++; $display("[TB] FAIL rand_dz[%0d] got lat=%0d dz=%b hi=%h lo=%h want lat=1 dz=1 hi=%h lo=%h",
                                    i, lat, dz, h, l, prev_h, prev_l);
                end
            end else begin
                ref_div(a, b, s, eq, er);
                total++; if (lat !== 34 || dz !== 1'b0 || l !== eq || h !== er) begin
                    bad++; $display("[TB] FAIL rand_div[%0d] %h/%h s=%b got lat=%0d dz=%b lo=%h hi=%h want lat=34 dz=0 lo=%h hi=%h",
                                    i, a, b, s, lat, dz, l, h, eq, er);
                end
                prev_l = eq;
                prev_h = er;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed_rules();
        test_overflow();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
